// File: rtl/freq_meter_bcd_if.sv
// rtl/freq_meter_bcd_if.sv - measurement input and result bus of the gated frequency meter
// The master side drives the measured signal and enable; the meter (slave) returns results.
interface freq_meter_bcd_if #(
  parameter int CNT_W  = 20,
  parameter int DIGITS = 4
);
  logic                  sig_i;
  logic                  en_i;
  logic [CNT_W-1:0]      freq_bin_o;
  logic [4*DIGITS-1:0]   freq_bcd_o;
  logic                  ovf_o;
  logic                  valid_o;
  logic                  busy_o;

  modport master (
    output sig_i,
    output en_i,
    input  freq_bin_o,
    input  freq_bcd_o,
    input  ovf_o,
    input  valid_o,
    input  busy_o
  );

  modport slave (
    input  sig_i,
    input  en_i,
    output freq_bin_o,
    output freq_bcd_o,
    output ovf_o,
    output valid_o,
    output busy_o
  );
endinterface

// File: rtl/freq_meter_bcd.sv
// rtl/freq_meter_bcd.sv - gated edge counter with binary and packed BCD result
// Counts synchronized rising edges of sig_i over GATE_CYCLES clocks, then latches the result.
module freq_meter_bcd #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int GATE_W      = 27,
  parameter int CNT_W       = 20,
  parameter int DIGITS      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  freq_meter_bcd_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic                  sp_q, sp_d;
  logic [GATE_W-1:0]     gate_q, gate_d;
  logic [CNT_W-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  wovf_q, wovf_d;
  logic [CNT_W-1:0]      fbin_q, fbin_d;
  logic [4*DIGITS-1:0]   fbcd_q, fbcd_d;
  logic                  fovf_q, fovf_d;
  logic                  valid_q, valid_d;

  logic                  edge_w;
  logic                  bin_sat;
  logic                  bcd_sat;
  logic                  carry;
  logic [CNT_W-1:0]      bin_inc;
  logic [4*DIGITS-1:0]   bcd_inc;

  // Two-flop synchronizer plus history flop for rising-edge detection.
  always_comb begin
    s1_d   = bus.sig_i;
    s2_d   = s1_q;
    sp_d   = s2_q;
    edge_w = s2_q & ~sp_q;
  end

  // Saturating increments; the BCD digits ripple their carry within one cycle.
  always_comb begin
    bin_sat = &bin_q;
    bin_inc = bin_sat ? bin_q : bin_q + CNT_W'(1);
    bcd_sat = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd9) begin
        bcd_sat = 1'b0;
      end
    end
    bcd_inc = bcd_q;
    carry   = ~bcd_sat;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    wovf_d  = wovf_q;
    fbin_d  = fbin_q;
    fbcd_d  = fbcd_q;
    fovf_d  = fovf_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gate_d = '0;
        bin_d  = '0;
        bcd_d  = '0;
        wovf_d = 1'b0;
        if (bus.en_i) begin
          state_d = GATE;
        end
      end
      GATE: begin
        if (!bus.en_i) begin
          // Abort: results stay as they were, counters clear via IDLE.
          state_d = IDLE;
        end else begin
          gate_d = gate_q + GATE_W'(1);
          if (edge_w) begin
            bin_d  = bin_inc;
            bcd_d  = bcd_inc;
            wovf_d = wovf_q | bin_sat | bcd_sat;
          end
          if (gate_q == GATE_LAST) begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        // Edges seen here are dropped; the next window starts from zero.
        fbin_d  = bin_q;
        fbcd_d  = bcd_q;
        fovf_d  = wovf_q;
        valid_d = 1'b1;
        gate_d  = '0;
        bin_d   = '0;
        bcd_d   = '0;
        wovf_d  = 1'b0;
        state_d = bus.en_i ? GATE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      sp_q    <= 1'b0;
      gate_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      wovf_q  <= 1'b0;
      fbin_q  <= '0;
      fbcd_q  <= '0;
      fovf_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      sp_q    <= sp_d;
      gate_q  <= gate_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      wovf_q  <= wovf_d;
      fbin_q  <= fbin_d;
      fbcd_q  <= fbcd_d;
      fovf_q  <= fovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.freq_bin_o = fbin_q;
  assign bus.freq_bcd_o = fbcd_q;
  assign bus.ovf_o      = fovf_q;
  assign bus.valid_o    = valid_q;
  assign bus.busy_o     = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter_bcd.sv
// tb/tb_freq_meter_bcd.sv - directed bench for freq_meter_bcd with 4-digit and 2-digit instances
// Both instances see the same sig_i/en_i; expected counts are worked out by hand.
module tb_freq_meter_bcd;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig = 1'b0;
  logic en  = 1'b0;
  logic man = 1'b0;

  int total  = 0;
  int bad    = 0;
  int period = 0;
  int ph     = 0;
  int vcnt   = 0;
  int n      = 0;
  int tmp    = 0;

  always #5 clk = ~clk;

  freq_meter_bcd_if #(.CNT_W(20), .DIGITS(4)) b4 ();
  freq_meter_bcd_if #(.CNT_W(20), .DIGITS(2)) b2 ();

  assign b4.sig_i = sig;
  assign b4.en_i  = en;
  assign b2.sig_i = sig;
  assign b2.en_i  = en;

  freq_meter_bcd #(.GATE_CYCLES(1000), .GATE_W(10), .CNT_W(20), .DIGITS(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b4)
  );

  freq_meter_bcd #(.GATE_CYCLES(1000), .GATE_W(10), .CNT_W(20), .DIGITS(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample on the falling edge, then drive sig_i for the next cycle.
  task automatic cyc1();
    @(negedge clk);
    if (b4.valid_o) vcnt++;
    if (period == 0) begin
      sig = man;
    end else begin
      sig = (ph < period / 2);
      ph  = (ph + 1) % period;
    end
  endtask

  task automatic cycn(input int cnt);
    for (int i = 0; i < cnt; i++) cyc1();
  endtask

  task automatic wait_valid(input int maxc, output int cnt);
    cnt = 0;
    do begin
      cyc1();
      cnt++;
    end while (!b4.valid_o && cnt < maxc);
    chk("valid_seen", b4.valid_o, 1);
  endtask

  initial begin
    cycn(2);
    chk("rst_bin",   b4.freq_bin_o, 0);
    chk("rst_bcd",   b4.freq_bcd_o, 0);
    chk("rst_ovf",   b4.ovf_o, 0);
    chk("rst_valid", b4.valid_o, 0);
    chk("rst_busy",  b4.busy_o, 0);

    // Period 10: 100 edges per window
    rst = 1'b1; en = 1'b1; period = 10; ph = 0;
    wait_valid(1100, n);
    chk("t1_bin4",   b4.freq_bin_o, 100);
    chk("t1_bcd4",   b4.freq_bcd_o, 16'h0100);
    chk("t1_ovf4",   b4.ovf_o, 0);
    chk("t1_busy",   b4.busy_o, 1);
    chk("t1_valid2", b2.valid_o, 1);
    chk("t1_bcd2",   b2.freq_bcd_o, 8'h99);
    chk("t1_ovf2",   b2.ovf_o, 1);
    wait_valid(1100, n);
    chk("t1_period", n, 1001);
    cyc1();
    chk("t1_pulse",  b4.valid_o, 0);

    // Static low input
    period = 0; man = 1'b0;
    wait_valid(1100, n);
    wait_valid(1100, n);
    chk("t2_bin4",   b4.freq_bin_o, 0);
    chk("t2_bcd4",   b4.freq_bcd_o, 0);
    chk("t2_bcd2",   b2.freq_bcd_o, 0);
    chk("t2_ovf2",   b2.ovf_o, 0);

    // Period 4: 250 edges saturates the 2-digit BCD
    period = 4; ph = 0;
    wait_valid(1100, n);
    wait_valid(1100, n);
    chk("t3_bin4",   b4.freq_bin_o, 250);
    chk("t3_bcd4",   b4.freq_bcd_o, 16'h0250);
    chk("t3_ovf4",   b4.ovf_o, 0);
    chk("t3_bin2",   b2.freq_bin_o, 250);
    chk("t3_bcd2",   b2.freq_bcd_o, 8'h99);
    chk("t3_ovf2",   b2.ovf_o, 1);
    period = 100; ph = 0;
    wait_valid(1100, n);
    wait_valid(1100, n);
    chk("t3b_bin2",  b2.freq_bin_o, 10);
    chk("t3b_bcd2",  b2.freq_bcd_o, 8'h10);
    chk("t3b_ovf2",  b2.ovf_o, 0);

    // Abort at gate cycle 500
    period = 10; ph = 0;
    cycn(500);
    en  = 1'b0;
    tmp = vcnt;
    cyc1();
    chk("t4_busy",   b4.busy_o, 0);
    chk("t4_valid",  b4.valid_o, 0);
    chk("t4_bin4",   b4.freq_bin_o, 10);
    chk("t4_bcd4",   b4.freq_bcd_o, 16'h0010);
    cycn(50);
    chk("t4_novalid", vcnt - tmp, 0);
    en = 1'b1;
    wait_valid(1100, n);
    chk("t4_latency", n, 1002);
    chk("t4_bin4r",  b4.freq_bin_o, 100);
    chk("t4_bcd4r",  b4.freq_bcd_o, 16'h0100);

    // Asynchronous reset at gate cycle 300
    cycn(300);
    rst = 1'b0;
    #1;
    chk("t5_bin4",   b4.freq_bin_o, 0);
    chk("t5_bcd4",   b4.freq_bcd_o, 0);
    chk("t5_busy",   b4.busy_o, 0);
    chk("t5_ovf2",   b2.ovf_o, 0);
    period = 0; man = 1'b0; sig = 1'b0;
    cycn(3);
    rst = 1'b1; period = 10; ph = 0;
    wait_valid(1100, n);
    chk("t5_latency", n, 1002);
    chk("t5_bin4",   b4.freq_bin_o, 100);

    // Single pulse on the last gate cycle, then one landing in LATCH
    period = 0; man = 1'b0;
    wait_valid(1100, n);
    wait_valid(1100, n);
    cycn(997);
    man = 1'b1; sig = 1'b1;
    cycn(2);
    man = 1'b0; sig = 1'b0;
    wait_valid(5, n);
    chk("t6_last_n",   n, 2);
    chk("t6_last_bin", b4.freq_bin_o, 1);
    chk("t6_last_bcd", b4.freq_bcd_o, 16'h0001);
    cycn(998);
    man = 1'b1; sig = 1'b1;
    cycn(2);
    man = 1'b0; sig = 1'b0;
    wait_valid(5, n);
    chk("t6_latch_n",   n, 1);
    chk("t6_latch_bin", b4.freq_bin_o, 0);
    wait_valid(1100, n);
    chk("t6_next_bin",  b4.freq_bin_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
